mem_arbiter: RTL and testbench

- Sits between the three memory requesters and the byte-serial memory controller: load/store buffer (LSB), instruction cache (IC) and instruction prefetcher (PF).
- Serialises their word/half/byte requests onto the controller's single activate interface.
- Tracks which requester owns the outstanding transaction and returns data only to that requester.
- Fixed priority (LSB > IC > PF), with an aging counter that guarantees IC forward progress. Supports flushing of speculative instruction fetches.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: owner codes (match the controller's
// task_src encoding), FSM state encoding and access-type codes.
package mem_arb_defs;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_LSB  = 2'b01;
  localparam logic [1:0] OWN_IC   = 2'b10;
  localparam logic [1:0] OWN_PF   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

  localparam logic [2:0] TYPE_W  = 3'b000;
  localparam logic [2:0] TYPE_HU = 3'b001;
  localparam logic [2:0] TYPE_BU = 3'b010;
  localparam logic [2:0] TYPE_H  = 3'b101;
  localparam logic [2:0] TYPE_B  = 3'b110;

  // Instruction-side owners (IC, PF) are the only ones a flush may kill.
  function automatic logic is_fetch_owner(input logic [1:0] owner);
    return owner[1];
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Fixed-priority winner selection (LSB > IC > PF) with IC starvation override.
module mem_arb_pick
  import mem_arb_defs::*;
(
  input  logic       lsb_v,
  input  logic       ic_v,
  input  logic       pf_v,
  input  logic       starve,
  output logic [1:0] winner
);

  // Priority encode the already-masked requests.
  always_comb begin
    winner = OWN_NONE;
    if (ic_v && starve) begin
      winner = OWN_IC;
    end else if (lsb_v) begin
      winner = OWN_LSB;
    end else if (ic_v) begin
      winner = OWN_IC;
    end else if (pf_v) begin
      winner = OWN_PF;
    end else begin
      winner = OWN_NONE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates LSB/IC/PF requests onto the single memory-controller interface.
// Optional perf counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_W     = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        lsb_req,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  input  logic        lsb_r_nw,
  input  logic [2:0]  lsb_type,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_rdata,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_done,
  output logic [31:0] pf_rdata,
  input  logic        flush_in,
  output logic        mc_activate,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic        mc_r_nw,
  output logic [2:0]  mc_type,
  input  logic        mc_ready,
  input  logic        mc_data_available,
  input  logic [31:0] mc_data_out,
  output logic [1:0]  owner_out
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_lsb_grants,
  output logic [31:0] perf_ic_grants,
  output logic [31:0] perf_pf_grants,
  output logic [31:0] perf_stall_cycles
`endif
);

  state_e              state_r;
  logic [1:0]          owner_r;
  logic [31:0]         addr_r;
  logic [31:0]         wdata_r;
  logic                r_nw_r;
  logic [2:0]          type_r;
  logic                kill_r;
  logic [STARVE_W-1:0] ic_cnt_r;
  logic [STARVE_W-1:0] ic_cnt_nxt_s;
  logic                lsb_done_r;
  logic                ic_done_r;
  logic                pf_done_r;
  logic [31:0]         lsb_rdata_r;
  logic [31:0]         ic_rdata_r;
  logic [31:0]         pf_rdata_r;

  logic                lsb_v_s;
  logic                ic_v_s;
  logic                pf_v_s;
  logic                starve_s;
  logic [1:0]          winner_s;
  logic                kill_now_s;
  logic                complete_s;
  logic                idle_s;

  // Request masking, starvation flag and completion detection.
  always_comb begin
    idle_s     = (state_r == ST_IDLE);
    lsb_v_s    = lsb_req & ~lsb_done_r;
    ic_v_s     = ic_req & ~ic_done_r & ~flush_in;
    pf_v_s     = pf_req & ~pf_done_r & ~flush_in;
    starve_s   = (ic_cnt_r >= STARVE_W'(STARVE_LIMIT));
    kill_now_s = kill_r | (flush_in & is_fetch_owner(owner_r));
    complete_s = 1'b0;
    if (state_r == ST_ISSUE) begin
      complete_s = mc_ready & mc_data_available;
    end else if (state_r == ST_WAIT) begin
      complete_s = mc_data_available;
    end else begin
      complete_s = 1'b0;
    end
  end

  mem_arb_pick u_pick (
    .lsb_v  (lsb_v_s),
    .ic_v   (ic_v_s),
    .pf_v   (pf_v_s),
    .starve (starve_s),
    .winner (winner_s)
  );

  // IC aging counter next value; a flush wipes accumulated credit.
  always_comb begin
    ic_cnt_nxt_s = ic_cnt_r;
    if (flush_in) begin
      ic_cnt_nxt_s = {STARVE_W{1'b0}};
    end else if (idle_s && (winner_s == OWN_IC)) begin
      ic_cnt_nxt_s = {STARVE_W{1'b0}};
    end else if (idle_s && ((winner_s == OWN_LSB) || (winner_s == OWN_PF)) && ic_req &&
                 (ic_cnt_r != {STARVE_W{1'b1}})) begin
      ic_cnt_nxt_s = ic_cnt_r + {{(STARVE_W-1){1'b0}}, 1'b1};
    end else begin
      ic_cnt_nxt_s = ic_cnt_r;
    end
  end

  // Arbitration FSM with latched request and registered responses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r     <= ST_IDLE;
      owner_r     <= OWN_NONE;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      r_nw_r      <= 1'b1;
      type_r      <= TYPE_W;
      kill_r      <= 1'b0;
      ic_cnt_r    <= {STARVE_W{1'b0}};
      lsb_done_r  <= 1'b0;
      ic_done_r   <= 1'b0;
      pf_done_r   <= 1'b0;
      lsb_rdata_r <= 32'h0000_0000;
      ic_rdata_r  <= 32'h0000_0000;
      pf_rdata_r  <= 32'h0000_0000;
    end else if (rdy_in) begin
      lsb_done_r <= 1'b0;
      ic_done_r  <= 1'b0;
      pf_done_r  <= 1'b0;
      ic_cnt_r   <= ic_cnt_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (winner_s != OWN_NONE) begin
            state_r <= ST_ISSUE;
            owner_r <= winner_s;
            kill_r  <= 1'b0;
          end
          case (winner_s)
            OWN_LSB: begin
              addr_r  <= lsb_addr;
              wdata_r <= lsb_wdata;
              r_nw_r  <= lsb_r_nw;
              type_r  <= lsb_type;
            end
            OWN_IC: begin
              addr_r  <= ic_addr;
              wdata_r <= 32'h0000_0000;
              r_nw_r  <= 1'b1;
              type_r  <= TYPE_W;
            end
            OWN_PF: begin
              addr_r  <= pf_addr;
              wdata_r <= 32'h0000_0000;
              r_nw_r  <= 1'b1;
              type_r  <= TYPE_W;
            end
            default: begin
              addr_r <= addr_r;
            end
          endcase
        end
        ST_ISSUE: begin
          // Once accepted, the response must be drained even if flushed.
          if (mc_ready) begin
            if (mc_data_available) begin
              state_r <= ST_IDLE;
              owner_r <= OWN_NONE;
              kill_r  <= 1'b0;
            end else begin
              state_r <= ST_WAIT;
              kill_r  <= kill_now_s;
            end
          end else if (flush_in && is_fetch_owner(owner_r)) begin
            state_r <= ST_IDLE;
            owner_r <= OWN_NONE;
            kill_r  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mc_data_available) begin
            state_r <= ST_IDLE;
            owner_r <= OWN_NONE;
            kill_r  <= 1'b0;
          end else if (flush_in && is_fetch_owner(owner_r)) begin
            kill_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          owner_r <= OWN_NONE;
          kill_r  <= 1'b0;
        end
      endcase
      if (complete_s && !kill_now_s) begin
        case (owner_r)
          OWN_LSB: begin
            lsb_done_r  <= 1'b1;
            lsb_rdata_r <= mc_data_out;
          end
          OWN_IC: begin
            ic_done_r  <= 1'b1;
            ic_rdata_r <= mc_data_out;
          end
          OWN_PF: begin
            pf_done_r  <= 1'b1;
            pf_rdata_r <= mc_data_out;
          end
          default: begin
            lsb_done_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mc_activate = (state_r == ST_ISSUE);
  assign mc_addr     = addr_r;
  assign mc_wdata    = wdata_r;
  assign mc_r_nw     = r_nw_r;
  assign mc_type     = type_r;
  assign owner_out   = owner_r;
  assign lsb_done    = lsb_done_r;
  assign ic_done     = ic_done_r;
  assign pf_done     = pf_done_r;
  assign lsb_rdata   = lsb_rdata_r;
  assign ic_rdata    = ic_rdata_r;
  assign pf_rdata    = pf_rdata_r;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_lsb_r;
  logic [31:0] perf_ic_r;
  logic [31:0] perf_pf_r;
  logic [31:0] perf_stall_r;

  // Saturating grant and stall counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_lsb_r   <= 32'h0000_0000;
      perf_ic_r    <= 32'h0000_0000;
      perf_pf_r    <= 32'h0000_0000;
      perf_stall_r <= 32'h0000_0000;
    end else if (rdy_in) begin
      if (idle_s && (winner_s == OWN_LSB) && (perf_lsb_r != 32'hFFFF_FFFF)) begin
        perf_lsb_r <= perf_lsb_r + 32'h0000_0001;
      end
      if (idle_s && (winner_s == OWN_IC) && (perf_ic_r != 32'hFFFF_FFFF)) begin
        perf_ic_r <= perf_ic_r + 32'h0000_0001;
      end
      if (idle_s && (winner_s == OWN_PF) && (perf_pf_r != 32'hFFFF_FFFF)) begin
        perf_pf_r <= perf_pf_r + 32'h0000_0001;
      end
      if ((state_r == ST_ISSUE) && !mc_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'h0000_0001;
      end
    end
  end

  assign perf_lsb_grants   = perf_lsb_r;
  assign perf_ic_grants    = perf_ic_r;
  assign perf_pf_grants    = perf_pf_r;
  assign perf_stall_cycles = perf_stall_r;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

  localparam logic [31:0] IC_A = 32'h0000_4000;
  localparam logic [31:0] PF_A = 32'h0000_8000;
  localparam logic [31:0] WD   = 32'h0000_00A5;
  localparam logic [31:0] DB   = 32'hDEAD_BEEF;
  localparam logic [31:0] R1   = 32'h1111_1111;
  localparam logic [31:0] R2   = 32'h2222_2222;
  localparam logic [31:0] R3   = 32'h3333_3333;
  localparam logic [31:0] R4   = 32'h4444_4444;
  localparam logic [31:0] AB   = 32'h0000_ABCD;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in;
  logic lsb_req, lsb_r_nw;
  logic [31:0] lsb_addr, lsb_wdata;
  logic [2:0] lsb_type;
  logic lsb_done, ic_done, pf_done;
  logic [31:0] lsb_rdata, ic_rdata, pf_rdata;
  logic ic_req, pf_req, flush_in;
  logic [31:0] ic_addr, pf_addr;
  logic mc_activate, mc_r_nw, mc_ready, mc_data_available;
  logic [31:0] mc_addr, mc_wdata, mc_data_out;
  logic [2:0] mc_type;
  logic [1:0] owner_out;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_lsb_grants, perf_ic_grants, perf_pf_grants, perf_stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_r_nw(lsb_r_nw),
    .lsb_type(lsb_type), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done), .pf_rdata(pf_rdata),
    .flush_in(flush_in), .mc_activate(mc_activate), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_r_nw(mc_r_nw), .mc_type(mc_type), .mc_ready(mc_ready),
    .mc_data_available(mc_data_available), .mc_data_out(mc_data_out), .owner_out(owner_out)
`ifdef MEM_ARB_PERF_EN
    , .perf_lsb_grants(perf_lsb_grants), .perf_ic_grants(perf_ic_grants),
    .perf_pf_grants(perf_pf_grants), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  typedef struct {
    logic        lreq;
    logic [31:0] laddr;
    logic        lnw;
    logic [2:0]  ltype;
    logic        ireq, preq, flush, mrdy, dav;
    logic [31:0] dat;
    logic [1:0]  own;
    logic        act;
    logic [2:0]  done;
    logic [31:0] lrd, ird, prd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic lreq, input logic [31:0] laddr, input logic lnw,
                              input logic [2:0] ltype, input logic ireq, input logic preq,
                              input logic flush, input logic mrdy, input logic dav,
                              input logic [31:0] dat, input logic [1:0] own, input logic act,
                              input logic [2:0] done, input logic [31:0] lrd,
                              input logic [31:0] ird, input logic [31:0] prd);
    vec_t v;
    v.lreq = lreq; v.laddr = laddr; v.lnw = lnw; v.ltype = ltype;
    v.ireq = ireq; v.preq = preq; v.flush = flush; v.mrdy = mrdy; v.dav = dav;
    v.dat = dat; v.own = own; v.act = act; v.done = done;
    v.lrd = lrd; v.ird = ird; v.prd = prd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_owner"}, 32'(owner_out), 32'h0);
    chk({p, "_act"}, 32'(mc_activate), 32'h0);
    chk({p, "_done"}, 32'({lsb_done, ic_done, pf_done}), 32'h0);
    chk({p, "_lrd"}, lsb_rdata, 32'h0);
    chk({p, "_ird"}, ic_rdata, 32'h0);
    chk({p, "_prd"}, pf_rdata, 32'h0);
    chk({p, "_addr"}, mc_addr, 32'h0);
    chk({p, "_wdata"}, mc_wdata, 32'h0);
    chk({p, "_rnw"}, 32'(mc_r_nw), 32'h1);
    chk({p, "_type"}, 32'(mc_type), 32'h0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    lsb_req = 1'b0; lsb_addr = 32'h0; lsb_wdata = WD; lsb_r_nw = 1'b1; lsb_type = 3'b000;
    ic_req = 1'b0; ic_addr = IC_A; pf_req = 1'b0; pf_addr = PF_A;
    mc_ready = 1'b0; mc_data_available = 1'b0; mc_data_out = 32'h0;
    step(); step();
    chk_reset("reset");
    rst_in = 1'b0;

    // Single LSB word load, response after a few wait cycles.
    vecs.push_back(mk(1, 32'h1000, 1, 3'b000, 0, 0, 0, 0, 0, 32'h0, 2'b01, 1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1000, 1, 3'b000, 0, 0, 0, 1, 0, 32'h0, 2'b01, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1000, 1, 3'b000, 0, 0, 0, 0, 0, 32'h0, 2'b01, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1000, 1, 3'b000, 0, 0, 0, 0, 0, 32'h0, 2'b01, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1000, 1, 3'b000, 0, 0, 0, 0, 0, 32'h0, 2'b01, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1000, 1, 3'b000, 0, 0, 0, 0, 1, DB, 2'b00, 0, 3'b100, DB, 0, 0));
    vecs.push_back(mk(1, 32'h1000, 1, 3'b000, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3'b000, DB, 0, 0));
    vecs.push_back(mk(0, 32'h1000, 1, 3'b000, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3'b000, DB, 0, 0));
    // All three requesters at once: LSB, IC, PF order.
    vecs.push_back(mk(1, 32'h2000, 1, 3'b000, 1, 1, 0, 1, 0, 32'h0, 2'b01, 1, 3'b000, DB, 0, 0));
    vecs.push_back(mk(1, 32'h2000, 1, 3'b000, 1, 1, 0, 1, 0, 32'h0, 2'b01, 0, 3'b000, DB, 0, 0));
    vecs.push_back(mk(1, 32'h2000, 1, 3'b000, 1, 1, 0, 0, 1, R1, 2'b00, 0, 3'b100, R1, 0, 0));
    vecs.push_back(mk(1, 32'h2000, 1, 3'b000, 1, 1, 0, 0, 0, 32'h0, 2'b10, 1, 3'b000, R1, 0, 0));
    vecs.push_back(mk(0, 32'h2000, 1, 3'b000, 1, 1, 0, 1, 0, 32'h0, 2'b10, 0, 3'b000, R1, 0, 0));
    vecs.push_back(mk(0, 32'h2000, 1, 3'b000, 1, 1, 0, 0, 1, R2, 2'b00, 0, 3'b010, R1, R2, 0));
    vecs.push_back(mk(0, 32'h2000, 1, 3'b000, 1, 1, 0, 0, 0, 32'h0, 2'b11, 1, 3'b000, R1, R2, 0));
    vecs.push_back(mk(0, 32'h2000, 1, 3'b000, 0, 1, 0, 1, 0, 32'h0, 2'b11, 0, 3'b000, R1, R2, 0));
    vecs.push_back(mk(0, 32'h2000, 1, 3'b000, 0, 1, 0, 0, 1, R3, 2'b00, 0, 3'b001, R1, R2, R3));
    vecs.push_back(mk(0, 32'h2000, 1, 3'b000, 0, 1, 0, 0, 0, 32'h0, 2'b00, 0, 3'b000, R1, R2, R3));
    vecs.push_back(mk(0, 32'h2000, 1, 3'b000, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3'b000, R1, R2, R3));
    // IC flushed while in WAIT: response swallowed, LSB then served normally.
    vecs.push_back(mk(0, 32'h3000, 1, 3'b000, 1, 0, 0, 0, 0, 32'h0, 2'b10, 1, 3'b000, R1, R2, R3));
    vecs.push_back(mk(0, 32'h3000, 1, 3'b000, 1, 0, 0, 1, 0, 32'h0, 2'b10, 0, 3'b000, R1, R2, R3));
    vecs.push_back(mk(0, 32'h3000, 1, 3'b000, 1, 0, 1, 0, 0, 32'h0, 2'b10, 0, 3'b000, R1, R2, R3));
    vecs.push_back(mk(0, 32'h3000, 1, 3'b000, 0, 0, 0, 0, 1, 32'h1234_5678, 2'b00, 0, 3'b000, R1, R2, R3));
    vecs.push_back(mk(1, 32'h3000, 1, 3'b000, 0, 0, 0, 0, 0, 32'h0, 2'b01, 1, 3'b000, R1, R2, R3));
    vecs.push_back(mk(1, 32'h3000, 1, 3'b000, 0, 0, 0, 1, 0, 32'h0, 2'b01, 0, 3'b000, R1, R2, R3));
    vecs.push_back(mk(1, 32'h3000, 1, 3'b000, 0, 0, 0, 0, 1, AB, 2'b00, 0, 3'b100, AB, R2, R3));
    vecs.push_back(mk(0, 32'h3000, 1, 3'b000, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3'b000, AB, R2, R3));
    // Byte store accepted and completed in the same ISSUE cycle.
    vecs.push_back(mk(1, 32'h30000, 0, 3'b010, 0, 0, 0, 0, 0, 32'h0, 2'b01, 1, 3'b000, AB, R2, R3));
    vecs.push_back(mk(1, 32'h30000, 0, 3'b010, 0, 0, 0, 1, 1, AB, 2'b00, 0, 3'b100, AB, R2, R3));
    vecs.push_back(mk(1, 32'h30000, 0, 3'b010, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3'b000, AB, R2, R3));
    vecs.push_back(mk(0, 32'h30000, 0, 3'b010, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3'b000, AB, R2, R3));
    // PF flushed in ISSUE before acceptance; flush masks fetches in IDLE.
    vecs.push_back(mk(0, 32'h0, 1, 3'b000, 0, 1, 0, 0, 0, 32'h0, 2'b11, 1, 3'b000, AB, R2, R3));
    vecs.push_back(mk(0, 32'h0, 1, 3'b000, 0, 1, 1, 0, 0, 32'h0, 2'b00, 0, 3'b000, AB, R2, R3));
    vecs.push_back(mk(0, 32'h0, 1, 3'b000, 0, 1, 0, 0, 0, 32'h0, 2'b11, 1, 3'b000, AB, R2, R3));
    vecs.push_back(mk(0, 32'h0, 1, 3'b000, 0, 1, 0, 1, 0, 32'h0, 2'b11, 0, 3'b000, AB, R2, R3));
    vecs.push_back(mk(0, 32'h0, 1, 3'b000, 0, 1, 0, 0, 1, R4, 2'b00, 0, 3'b001, AB, R2, R4));
    vecs.push_back(mk(0, 32'h0, 1, 3'b000, 1, 1, 1, 0, 0, 32'h0, 2'b00, 0, 3'b000, AB, R2, R4));
    vecs.push_back(mk(0, 32'h0, 1, 3'b000, 1, 0, 1, 0, 0, 32'h0, 2'b00, 0, 3'b000, AB, R2, R4));
    vecs.push_back(mk(0, 32'h0, 1, 3'b000, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3'b000, AB, R2, R4));

    for (int i = 0; i < vecs.size(); i++) begin
      lsb_req = vecs[i].lreq; lsb_addr = vecs[i].laddr; lsb_r_nw = vecs[i].lnw;
      lsb_type = vecs[i].ltype; ic_req = vecs[i].ireq; pf_req = vecs[i].preq;
      flush_in = vecs[i].flush; mc_ready = vecs[i].mrdy; mc_data_available = vecs[i].dav;
      mc_data_out = vecs[i].dat;
      step();
      chk($sformatf("v%0d_owner", i), 32'(owner_out), 32'(vecs[i].own));
      chk($sformatf("v%0d_act", i), 32'(mc_activate), 32'(vecs[i].act));
      chk($sformatf("v%0d_done", i), 32'({lsb_done, ic_done, pf_done}), 32'(vecs[i].done));
      chk($sformatf("v%0d_lrd", i), lsb_rdata, vecs[i].lrd);
      chk($sformatf("v%0d_ird", i), ic_rdata, vecs[i].ird);
      chk($sformatf("v%0d_prd", i), pf_rdata, vecs[i].prd);
      if (vecs[i].act) begin
        chk($sformatf("v%0d_addr", i), mc_addr,
            (vecs[i].own == 2'b01) ? vecs[i].laddr : ((vecs[i].own == 2'b10) ? IC_A : PF_A));
        chk($sformatf("v%0d_rnw", i), 32'(mc_r_nw), (vecs[i].own == 2'b01) ? 32'(vecs[i].lnw) : 32'h1);
        chk($sformatf("v%0d_type", i), 32'(mc_type), (vecs[i].own == 2'b01) ? 32'(vecs[i].ltype) : 32'h0);
        if (vecs[i].own == 2'b01) chk($sformatf("v%0d_wdata", i), mc_wdata, WD);
      end
    end
    flush_in = 1'b0; mc_ready = 1'b0; mc_data_available = 1'b0;
    lsb_req = 1'b0; ic_req = 1'b0; pf_req = 1'b0;

    // Starvation: four LSB wins against a waiting IC, then IC pre-empts.
    rst_in = 1'b1; step(); rst_in = 1'b0;
    lsb_addr = 32'h5000; lsb_r_nw = 1'b1; lsb_type = 3'b000;
    for (int r = 0; r < 4; r++) begin
      lsb_req = 1'b1; ic_req = 1'b1; step();
      chk($sformatf("starve_r%0d_lsb_grant", r), 32'(owner_out), 32'h1);
      mc_ready = 1'b1; step(); mc_ready = 1'b0;
      mc_data_available = 1'b1; mc_data_out = 32'(r); step(); mc_data_available = 1'b0;
      chk($sformatf("starve_r%0d_done", r), 32'(lsb_done), 32'h1);
      ic_req = 1'b0; step();
      chk($sformatf("starve_r%0d_idle", r), 32'(owner_out), 32'h0);
    end
    lsb_req = 1'b1; ic_req = 1'b1; step();
    chk("starve_ic_grant", 32'(owner_out), 32'h2);
    chk("starve_cnt_clear", 32'(dut.ic_cnt_r), 32'h0);
    mc_ready = 1'b1; step(); mc_ready = 1'b0;
    mc_data_available = 1'b1; mc_data_out = 32'h0000_0C0C; step(); mc_data_available = 1'b0;
    chk("starve_ic_done", 32'(ic_done), 32'h1);
    chk("starve_ic_rdata", ic_rdata, 32'h0000_0C0C);
    ic_req = 1'b1; step();
    chk("starve_lsb_after", 32'(owner_out), 32'h1);
    mc_ready = 1'b1; step(); mc_ready = 1'b0;
    mc_data_available = 1'b1; step(); mc_data_available = 1'b0;
    lsb_req = 1'b0; ic_req = 1'b0; step();

    // Reset during WAIT, then a stale response.
    lsb_req = 1'b1; lsb_addr = 32'h7000; step();
    mc_ready = 1'b1; step(); mc_ready = 1'b0;
    chk("rstwait_in_wait", 32'(owner_out), 32'h1);
    rst_in = 1'b1; lsb_req = 1'b0; step();
    chk_reset("rstwait");
    rst_in = 1'b0; mc_data_available = 1'b1; mc_data_out = 32'hFFFF_FFFF; step();
    mc_data_available = 1'b0;
    chk_reset("stale");

    // rdy_in low for three cycles while in ISSUE, then done held by rdy_in low.
    lsb_req = 1'b1; lsb_addr = 32'h6000; step();
    chk("stall_issue", 32'(mc_activate), 32'h1);
    rdy_in = 1'b0; mc_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall_act%0d", k), 32'(mc_activate), 32'h1);
      chk($sformatf("stall_own%0d", k), 32'(owner_out), 32'h1);
      chk($sformatf("stall_addr%0d", k), mc_addr, 32'h6000);
    end
    rdy_in = 1'b1; step(); mc_ready = 1'b0;
    chk("stall_wait", 32'(mc_activate), 32'h0);
    mc_data_available = 1'b1; mc_data_out = 32'h0000_0055; step(); mc_data_available = 1'b0;
    chk("stall_done", 32'(lsb_done), 32'h1);
    rdy_in = 1'b0; lsb_req = 1'b0; step();
    chk("stall_done_hold", 32'(lsb_done), 32'h1);
    rdy_in = 1'b1; step();
    chk("stall_done_clear", 32'(lsb_done), 32'h0);
    chk("stall_rdata", lsb_rdata, 32'h0000_0055);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
